// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and address helpers for the fetch-PC unit.
package pc_pkg;

   // Fetch handshake states: IDLE issues nothing, REQ presents pc_o to imem.
   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } fetch_state_e;

   // Next-PC source, highest priority first.
   typedef enum logic [2:0] {
      TRAP     = 3'd0,
      REDIRECT = 3'd1,
      RAS      = 3'd2,
      SEQ      = 3'd3,
      HOLD     = 3'd4
   } npc_sel_e;

   // Widest address the helpers handle; callers zero-extend into it.
   localparam int unsigned PC_MAX_W = 64;

   // Clear the low bits below the instruction granule.
   function automatic logic [PC_MAX_W-1:0] align_pc(input logic [PC_MAX_W-1:0] addr,
                                                    input int unsigned instr_bytes);
      logic [PC_MAX_W-1:0] low_mask;
      low_mask = PC_MAX_W'(instr_bytes - 1);
      return addr & ~low_mask;
   endfunction

   // True when any bit below the instruction granule is set.
   function automatic logic is_misaligned(input logic [PC_MAX_W-1:0] addr,
                                          input int unsigned instr_bytes);
      logic [PC_MAX_W-1:0] low_mask;
      low_mask = PC_MAX_W'(instr_bytes - 1);
      return (addr & low_mask) != '0;
   endfunction

endpackage

// File: rtl/pc_fetch_unit_ras.sv
// Return-address stack: circular buffer with a top pointer and a saturating
// count. A push when full silently overwrites the oldest entry; a pop when
// empty is ignored. Push and pop together replace the top in place.
module pc_ras
   import pc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RAS_DEPTH  = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_pc_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] top_o,
   output logic                  empty_o,
   output logic                  full_o
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_WIDTH-1:0] mem_q [RAS_DEPTH];
   logic [PTR_W-1:0]      top_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  do_pop;
   logic                  swap;
   logic [PTR_W-1:0]      wr_ptr;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CNT_W'(RAS_DEPTH));
   assign top_o   = mem_q[top_q];

   assign do_pop  = pop_i && !empty_o;
   assign swap    = push_i && do_pop;
   // A simultaneous pop+push rewrites the current top instead of advancing.
   assign wr_ptr  = swap ? top_q : top_q + PTR_W'(1);

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         top_q <= '0;
         cnt_q <= '0;
      end else if (swap) begin
         top_q <= top_q;
      end else if (push_i) begin
         top_q <= top_q + PTR_W'(1);
         if (!full_o) cnt_q <= cnt_q + CNT_W'(1);
      end else if (do_pop) begin
         top_q <= top_q - PTR_W'(1);
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   // Entry storage; contents are only meaningful below the count.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr] <= push_pc_i;
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-PC unit: holds the fetch PC, issues imem requests over valid/ready,
// and picks the next PC from trap, redirect, RAS prediction or PC+granule.
// Redirects arriving while a request waits for ready are parked in pending
// registers so the presented address never changes mid-handshake.
module pc_fetch_unit
   import pc_pkg::*;
#(
   parameter int unsigned            DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0]  RESET_VECTOR = DATA_WIDTH'(32'h0000_0000),
   parameter int unsigned            INSTR_BYTES  = 4,
   parameter int unsigned            RAS_DEPTH    = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  stall_i,
   output logic                  imem_req_o,
   input  logic                  imem_ready_i,
   output logic [DATA_WIDTH-1:0] pc_o,
   output logic                  drop_o,
   input  logic                  trap_i,
   input  logic [DATA_WIDTH-1:0] trap_pc_i,
   input  logic                  redirect_i,
   input  logic [DATA_WIDTH-1:0] redirect_pc_i,
   input  logic                  ras_push_i,
   input  logic [DATA_WIDTH-1:0] ras_push_pc_i,
   input  logic                  ras_pop_i,
   output logic                  misalign_o,
   output logic                  ras_empty_o
);

   fetch_state_e          state_q;
   logic [DATA_WIDTH-1:0] pc_q;
   logic                  trap_pend_q;
   logic [DATA_WIDTH-1:0] trap_pend_pc_q;
   logic                  redir_pend_q;
   logic [DATA_WIDTH-1:0] redir_pend_pc_q;
   logic                  misalign_q;

   logic                  fire;
   logic                  upd_win;
   npc_sel_e              npc_sel;
   logic [DATA_WIDTH-1:0] tgt_raw;
   logic                  redirecting;
   logic [DATA_WIDTH-1:0] pc_next;
   logic                  misalign_next;

   logic                  ras_push_en;
   logic                  ras_pop_en;
   logic [DATA_WIDTH-1:0] ras_top;
   logic                  ras_empty;
   // Full flag is not needed for next-PC selection.
   logic                  ras_full_unused;

   assign fire    = (state_q == REQ) && imem_ready_i;
   // PC may change on an accepted request or at any time while idle.
   assign upd_win = fire || (state_q == IDLE);

   assign imem_req_o  = (state_q == REQ);
   assign pc_o        = pc_q;
   assign misalign_o  = misalign_q;
   assign ras_empty_o = ras_empty;
   assign drop_o      = fire && (trap_i || redirect_i || trap_pend_q || redir_pend_q);

   // Prediction state only advances on good-path accepted fetches.
   assign ras_push_en = fire && !drop_o && ras_push_i;
   assign ras_pop_en  = fire && !drop_o && ras_pop_i;

   // Next-PC source priority: trap, redirect, RAS prediction, sequential.
   always_comb begin
      npc_sel = HOLD;
      tgt_raw = pc_q;
      if (upd_win) begin
         if (trap_i) begin
            npc_sel = TRAP;
            tgt_raw = trap_pc_i;
         end else if (trap_pend_q) begin
            npc_sel = TRAP;
            tgt_raw = trap_pend_pc_q;
         end else if (redirect_i) begin
            npc_sel = REDIRECT;
            tgt_raw = redirect_pc_i;
         end else if (redir_pend_q) begin
            npc_sel = REDIRECT;
            tgt_raw = redir_pend_pc_q;
         end else if (fire && ras_pop_i && !ras_empty) begin
            npc_sel = RAS;
            tgt_raw = ras_top;
         end else if (fire) begin
            npc_sel = SEQ;
            tgt_raw = pc_q + DATA_WIDTH'(INSTR_BYTES);
         end
      end
   end

   // Only externally supplied targets can carry stray low bits.
   assign redirecting   = (npc_sel == TRAP) || (npc_sel == REDIRECT);
   assign pc_next       = redirecting ? DATA_WIDTH'(align_pc(PC_MAX_W'(tgt_raw), INSTR_BYTES))
                                      : tgt_raw;
   assign misalign_next = redirecting && is_misaligned(PC_MAX_W'(tgt_raw), INSTR_BYTES);

   // Handshake FSM, PC register, pending-valid flags and misalign pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         pc_q         <= RESET_VECTOR;
         trap_pend_q  <= 1'b0;
         redir_pend_q <= 1'b0;
         misalign_q   <= 1'b0;
      end else begin
         misalign_q <= misalign_next;
         if (npc_sel != HOLD) pc_q <= pc_next;

         unique case (state_q)
            IDLE: if (!stall_i) state_q <= REQ;
            REQ:  if (fire && stall_i) state_q <= IDLE;
         endcase

         if (upd_win) begin
            // A trap flushes everything older, including a parked redirect.
            if (npc_sel == TRAP) begin
               trap_pend_q  <= 1'b0;
               redir_pend_q <= 1'b0;
            end else if (npc_sel == REDIRECT) begin
               redir_pend_q <= 1'b0;
            end
         end else begin
            // Waiting for ready: park redirects; a trap outranks any redirect.
            if (trap_i) begin
               trap_pend_q  <= 1'b1;
               redir_pend_q <= 1'b0;
            end else if (redirect_i && !trap_pend_q) begin
               redir_pend_q <= 1'b1;
            end
         end
      end
   end

   // Pending target addresses, captured alongside their valid flags.
   always_ff @(posedge clk_i) begin
      if (!upd_win) begin
         if (trap_i) trap_pend_pc_q <= trap_pc_i;
         else if (redirect_i && !trap_pend_q) redir_pend_pc_q <= redirect_pc_i;
      end
   end

   pc_ras #(
      .DATA_WIDTH (DATA_WIDTH),
      .RAS_DEPTH  (RAS_DEPTH)
   ) u_ras (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push_i    (ras_push_en),
      .push_pc_i (ras_push_pc_i),
      .pop_i     (ras_pop_en),
      .top_o     (ras_top),
      .empty_o   (ras_empty),
      .full_o    (ras_full_unused)
   );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit with RESET_VECTOR 0x1000, 4-byte granule, 4-deep RAS.
module tb_pc_fetch_unit;

   localparam logic [31:0] RV = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst, stall, ready, trap, redir, push, pop;
   logic [31:0] trap_pc, redir_pc, push_pc;
   logic        req, drop, mis, empty;
   logic [31:0] pc;

   always #5 clk = ~clk;

   pc_fetch_unit #(
      .DATA_WIDTH   (32),
      .RESET_VECTOR (RV),
      .INSTR_BYTES  (4),
      .RAS_DEPTH    (4)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .stall_i       (stall),
      .imem_req_o    (req),
      .imem_ready_i  (ready),
      .pc_o          (pc),
      .drop_o        (drop),
      .trap_i        (trap),
      .trap_pc_i     (trap_pc),
      .redirect_i    (redir),
      .redirect_pc_i (redir_pc),
      .ras_push_i    (push),
      .ras_push_pc_i (push_pc),
      .ras_pop_i     (pop),
      .misalign_o    (mis),
      .ras_empty_o   (empty)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: fetch-level state, RAS as a list of return addresses.
   bit          m_ok = 1'b0;
   bit          m_req;
   logic [31:0] m_pc;
   bit          m_pt, m_pr;
   logic [31:0] m_pt_pc, m_pr_pc;
   bit          m_mis;
   logic [31:0] m_ras[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit m_drop();
      return m_req && ready && (trap || redir || m_pt || m_pr);
   endfunction

   task automatic model_step();
      bit          fire, win, drp;
      logic [31:0] tgt;
      if (rst) begin
         m_ok = 1'b1; m_req = 1'b0; m_pc = RV; m_pt = 1'b0; m_pr = 1'b0; m_mis = 1'b0;
         m_ras.delete();
         return;
      end
      fire  = m_req && ready;
      win   = fire || !m_req;
      drp   = m_drop();
      m_mis = 1'b0;
      if (win) begin
         if (trap || m_pt) begin
            tgt   = trap ? trap_pc : m_pt_pc;
            m_pc  = (tgt / 4) * 4;
            m_mis = (tgt % 4) != 0;
            m_pt  = 1'b0;
            m_pr  = 1'b0;
         end else if (redir || m_pr) begin
            tgt   = redir ? redir_pc : m_pr_pc;
            m_pc  = (tgt / 4) * 4;
            m_mis = (tgt % 4) != 0;
            m_pr  = 1'b0;
         end else if (fire && pop && m_ras.size() > 0) begin
            m_pc = m_ras[m_ras.size()-1];
         end else if (fire) begin
            m_pc = m_pc + 32'd4;
         end
         if (fire && !drp) begin
            if (push && pop && m_ras.size() > 0) begin
               m_ras[m_ras.size()-1] = push_pc;
            end else if (push) begin
               m_ras.push_back(push_pc);
               if (m_ras.size() > 4) void'(m_ras.pop_front());
            end else if (pop && m_ras.size() > 0) begin
               void'(m_ras.pop_back());
            end
         end
      end else begin
         if (trap) begin
            m_pt = 1'b1; m_pt_pc = trap_pc; m_pr = 1'b0;
         end else if (redir && !m_pt) begin
            m_pr = 1'b1; m_pr_pc = redir_pc;
         end
      end
      m_req = win ? !stall : 1'b1;
   endtask

   task automatic compare();
      if (!m_ok) return;
      chk("pc", pc, m_pc);
      chk("req", {31'b0, req}, {31'b0, m_req});
      chk("drop", {31'b0, drop}, {31'b0, m_drop()});
      chk("misalign", {31'b0, mis}, {31'b0, m_mis});
      chk("ras_empty", {31'b0, empty}, {31'b0, m_ras.size() == 0});
   endtask

   // One clock: compare mid-cycle, advance the model on the edge.
   task automatic tick();
      @(negedge clk);
      compare();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic lit_pc(input string nm, input logic [31:0] exp);
      chk(nm, pc, exp);
      chk({nm, "_model"}, m_pc, exp);
   endtask

   task automatic lit_bit(input string nm, input logic act, input logic exp);
      chk(nm, {31'b0, act}, {31'b0, exp});
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; ready = 1'b0; trap = 1'b0; redir = 1'b0;
      push = 1'b0; pop = 1'b0; trap_pc = '0; redir_pc = '0; push_pc = '0;
      tick();

      // Sequential fetch out of reset
      rst = 1'b0; ready = 1'b1;
      lit_pc("rst_pc", 32'h1000);
      lit_bit("rst_req", req, 1'b0);
      lit_bit("rst_empty", empty, 1'b1);
      lit_bit("rst_mis", mis, 1'b0);
      tick();
      lit_bit("seq_req", req, 1'b1);
      lit_pc("seq_pc0", 32'h1000);
      tick(); lit_pc("seq_pc1", 32'h1004);
      tick(); lit_pc("seq_pc2", 32'h1008);

      // Redirect while imem not ready
      ready = 1'b0; redir = 1'b1; redir_pc = 32'h2000;
      tick(); lit_pc("redir_hold0", 32'h1008);
      redir = 1'b0;
      tick(); lit_pc("redir_hold1", 32'h1008);
      ready = 1'b1; #1;
      lit_bit("redir_drop", drop, 1'b1);
      tick(); lit_pc("redir_pc", 32'h2000);

      // Trap beats redirect; later redirect does not displace pending trap
      ready = 1'b0; trap = 1'b1; trap_pc = 32'h0100; redir = 1'b1; redir_pc = 32'h3000;
      tick();
      trap = 1'b0; redir = 1'b1; redir_pc = 32'h3004;
      tick(); lit_pc("trap_hold", 32'h2000);
      redir = 1'b0; ready = 1'b1; #1;
      lit_bit("trap_drop", drop, 1'b1);
      tick(); lit_pc("trap_pc", 32'h0100);
      tick(); lit_pc("trap_after", 32'h0104);

      // RAS overflow then drain
      push = 1'b1;
      push_pc = 32'hA0; tick();
      push_pc = 32'hA4; tick();
      push_pc = 32'hA8; tick();
      push_pc = 32'hAC; tick();
      push_pc = 32'hB0; tick();
      lit_pc("ras_seq", 32'h0118);
      push = 1'b0; pop = 1'b1;
      tick(); lit_pc("ras_pop1", 32'hB0);
      tick(); lit_pc("ras_pop2", 32'hAC);
      tick(); lit_pc("ras_pop3", 32'hA8);
      lit_bit("ras_not_empty", empty, 1'b0);
      tick(); lit_pc("ras_pop4", 32'hA4);
      lit_bit("ras_empty4", empty, 1'b1);
      tick(); lit_pc("ras_pop5_seq", 32'hA8);
      pop = 1'b0;

      // Misaligned redirect and address wrap
      redir = 1'b1; redir_pc = 32'h2002; #1;
      lit_bit("mis_drop", drop, 1'b1);
      tick(); lit_pc("mis_pc", 32'h2000);
      lit_bit("mis_pulse", mis, 1'b1);
      redir = 1'b0;
      tick(); lit_pc("mis_next", 32'h2004);
      lit_bit("mis_clear", mis, 1'b0);
      redir = 1'b1; redir_pc = 32'hFFFF_FFFC;
      tick(); lit_pc("wrap_top", 32'hFFFF_FFFC);
      redir = 1'b0;
      tick(); lit_pc("wrap_zero", 32'h0000_0000);

      // Stall on fire, trap while idle, reset mid-request
      stall = 1'b1; push = 1'b1; push_pc = 32'hC0;
      tick(); lit_pc("stall_pc", 32'h0004);
      lit_bit("stall_req", req, 1'b0);
      lit_bit("stall_push", empty, 1'b0);
      push = 1'b0;
      tick(); lit_pc("idle_hold", 32'h0004);
      trap = 1'b1; trap_pc = 32'h0203;
      tick(); lit_pc("idle_trap", 32'h0200);
      lit_bit("idle_trap_mis", mis, 1'b1);
      trap = 1'b0; stall = 1'b0;
      tick(); lit_bit("idle_to_req", req, 1'b1);
      ready = 1'b0; redir = 1'b1; redir_pc = 32'h5000;
      tick();
      redir = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      lit_bit("midrst_req", req, 1'b0);
      lit_pc("midrst_pc", 32'h1000);
      lit_bit("midrst_empty", empty, 1'b1);
      ready = 1'b1;
      tick();
      tick(); lit_pc("midrst_no_pend", 32'h1004);

      // Mixed traffic against the model
      for (int i = 0; i < 400; i++) begin
         rst      = ($urandom_range(0, 149) == 0);
         ready    = ($urandom_range(0, 3) != 0);
         stall    = ($urandom_range(0, 7) == 0);
         trap     = ($urandom_range(0, 19) == 0);
         redir    = ($urandom_range(0, 7) == 0);
         push     = ($urandom_range(0, 3) == 0);
         pop      = ($urandom_range(0, 3) == 0);
         trap_pc  = $urandom;
         redir_pc = $urandom;
         push_pc  = $urandom & 32'hFFFF_FFFC;
         tick();
      end
      rst = 1'b0; trap = 1'b0; redir = 1'b0; push = 1'b0; pop = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
